// File: rtl/jstk_spi_master.sv
// jstk_spi_master -- SPI mode-0 master that polls a joystick module.
//
// One accepted start runs a 5-byte exchange with cs_n held low throughout.
// Byte 0 carries the LED command and bytes 1-4 are zero. The five returned
// bytes are decoded into a 10-bit X position, a 10-bit Y position and three
// button bits.
//
// Ports:
//   clk      system clock; all logic runs on its rising edge
//   reset    synchronous, active-high
//   start    request one transaction; only sampled while idle
//   led_cmd  two LED bits for byte 0, captured when start is accepted
//   miso     serial data from the slave
//   sclk     SPI clock (mode 0: idles low, data sampled on the rising edge)
//   mosi     serial data to the slave, MSB first
//   cs_n     active-low chip select
//   busy     high from the accepted start until the done cycle
//   done     one-cycle pulse carrying the freshly updated outputs
//   x_pos    last received X position
//   y_pos    last received Y position
//   btn      last received button bits
module jstk_spi_master #(
  parameter int CLK_DIV  = 50,
  parameter int CS_SETUP = 2500,
  parameter int BYTE_GAP = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] led_cmd,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  output logic       busy,
  output logic       done,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic [2:0] btn
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] SHIFT  = 3'd2;
  localparam logic [2:0] GAP    = 3'd3;
  localparam logic [2:0] FINISH = 3'd4;

  // One shared cycle counter covers the setup delay, the byte gap and the
  // sclk half-period, so it must hold the largest of the three.
  localparam int MAX_AB = (CS_SETUP > BYTE_GAP) ? CS_SETUP : BYTE_GAP;
  localparam int MAX_V  = (MAX_AB > CLK_DIV) ? MAX_AB : CLK_DIV;
  localparam int CW     = $clog2(MAX_V + 1);

  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(BYTE_GAP - 1);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [2:0]    byte_idx;
  logic [6:0]    tx_rest;   // bits still to be sent after the one on mosi
  logic [7:0]    rx_sr;
  logic [7:0]    rx0;
  logic [1:0]    rx1;
  logic [7:0]    rx2;
  logic [1:0]    rx3;
  logic [7:0]    tx_byte0;

  always_comb begin
    tx_byte0 = {6'b100000, led_cmd};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cs_n     <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      x_pos    <= '0;
      y_pos    <= '0;
      btn      <= '0;
      cnt      <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      tx_rest  <= '0;
      rx_sr    <= '0;
      rx0      <= '0;
      rx1      <= '0;
      rx2      <= '0;
      rx3      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cs_n     <= 1'b1;
          sclk     <= 1'b0;
          mosi     <= 1'b0;
          busy     <= 1'b0;
          cnt      <= '0;
          bit_cnt  <= '0;
          byte_idx <= '0;
          if (start) begin
            state   <= SETUP;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            mosi    <= tx_byte0[7];
            tx_rest <= tx_byte0[6:0];
          end
        end

        // The edge that leaves SETUP or GAP is also the first rising sclk
        // edge of the byte, so miso is sampled here as well.
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt   <= '0;
            state <= SHIFT;
            sclk  <= 1'b1;
            rx_sr <= {rx_sr[6:0], miso};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= SHIFT;
            sclk  <= 1'b1;
            rx_sr <= {rx_sr[6:0], miso};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // A byte spans eight full sclk periods; its last low half-period
        // is spent here before moving on, which keeps every bit 2*CLK_DIV
        // cycles long and leaves sclk low into GAP.
        SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (sclk) begin
              sclk <= 1'b0;
              if (bit_cnt != 3'd7) begin
                mosi    <= tx_rest[6];
                tx_rest <= {tx_rest[5:0], 1'b0};
              end
            end else if (bit_cnt == 3'd7) begin
              bit_cnt <= 3'd0;
              case (byte_idx)
                3'd0:    rx0 <= rx_sr;
                3'd1:    rx1 <= rx_sr[1:0];
                3'd2:    rx2 <= rx_sr;
                3'd3:    rx3 <= rx_sr[1:0];
                default: ;
              endcase
              if (byte_idx == 3'd4) begin
                state <= FINISH;
                done  <= 1'b1;
                busy  <= 1'b0;
                x_pos <= {rx1, rx0};
                y_pos <= {rx3, rx2};
                btn   <= rx_sr[2:0];
              end else begin
                byte_idx <= byte_idx + 1'b1;
                state    <= GAP;
                mosi     <= 1'b0;
                tx_rest  <= '0;
              end
            end else begin
              sclk    <= 1'b1;
              rx_sr   <= {rx_sr[6:0], miso};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        FINISH: begin
          state <= IDLE;
          cs_n  <= 1'b1;
          mosi  <= 1'b0;
          sclk  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          cs_n  <= 1'b1;
          sclk  <= 1'b0;
          mosi  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jstk_spi_master.sv
// Directed bench for jstk_spi_master with short timing parameters.
module tb_jstk_spi_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] led_cmd;
  logic       miso;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic       busy;
  logic       done;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [2:0] btn;

  jstk_spi_master #(
    .CLK_DIV (2),
    .CS_SETUP(4),
    .BYTE_GAP(4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .led_cmd(led_cmd),
    .miso   (miso),
    .sclk   (sclk),
    .mosi   (mosi),
    .cs_n   (cs_n),
    .busy   (busy),
    .done   (done),
    .x_pos  (x_pos),
    .y_pos  (y_pos),
    .btn    (btn)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Slave model: 40 bits streamed MSB first; the next bit appears on each
  // falling sclk edge, the first one when cs_n falls.
  logic [39:0] slave_bits;
  int          sidx = 0;
  logic        glitch_en = 1'b0;
  logic        gp = 1'b0;

  assign miso = (sidx < 40) ? (slave_bits[39 - sidx] ^ gp) : 1'b0;

  always begin
    @(negedge cs_n);
    sidx = 0;
    while (!cs_n) begin
      @(negedge sclk or posedge cs_n);
      if (!cs_n) sidx++;
    end
  end

  // Corrupts miso between just after each rising clk edge and the next
  // falling edge; the value at every rising clk edge stays correct.
  always begin
    @(posedge clk);
    #1 gp = glitch_en;
    @(negedge clk);
    gp = 1'b0;
  end

  // Passive monitor, sampled on the falling clk edge.
  int          cyc = 0;
  int          rises = 0;
  int          sclk_hi = 0;
  int          cs_low = 0;
  int          done_cnt = 0;
  int          idle_err = 0;
  int          fall_cyc = 0;
  int          first_rise_cyc = 0;
  logic        need_first = 1'b0;
  logic        sclk_q = 1'b0;
  logic        cs_q = 1'b1;
  logic [39:0] mosi_cap = '0;

  always @(negedge clk) begin
    cyc++;
    if (cs_n === 1'b0) cs_low++;
    if (done === 1'b1) done_cnt++;
    if (sclk === 1'b1) sclk_hi++;
    if (cs_n === 1'b1 && (mosi !== 1'b0 || sclk !== 1'b0)) idle_err++;
    if (cs_n === 1'b0 && cs_q === 1'b1) begin
      fall_cyc   = cyc;
      need_first = 1'b1;
    end
    if (sclk === 1'b1 && sclk_q === 1'b0 && cs_n === 1'b0) begin
      rises++;
      mosi_cap = {mosi_cap[38:0], mosi};
      if (need_first) begin
        first_rise_cyc = cyc;
        need_first     = 1'b0;
      end
    end
    sclk_q = sclk;
    cs_q   = cs_n;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int lim);
    int k;
    k = 0;
    while (done !== 1'b1 && k < lim) begin
      tick();
      k++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
  endtask

  task automatic wait_rises(input string tag, input int target, input int lim);
    int k;
    k = 0;
    while (rises < target && k < lim) begin
      tick();
      k++;
    end
    check({tag, "_rise_seen"}, (rises >= target), 1'b1);
  endtask

  localparam logic [39:0] DATA_A = {8'h34, 8'hF2, 8'h78, 8'h01, 8'hFD};
  localparam logic [39:0] DATA_B = {8'h5A, 8'hFF, 8'hC3, 8'hFE, 8'hFA};

  int r0, c0, d0, h0;

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    led_cmd    = 2'b00;
    slave_bits = DATA_A;
    repeat (3) tick();
    check("rst_cs_n",  cs_n,  1'b1);
    check("rst_sclk",  sclk,  1'b0);
    check("rst_mosi",  mosi,  1'b0);
    check("rst_busy",  busy,  1'b0);
    check("rst_done",  done,  1'b0);
    check("rst_x",     x_pos, 10'h000);
    check("rst_y",     y_pos, 10'h000);
    check("rst_btn",   btn,   3'b000);
    reset = 1'b0;
    tick();

    // Basic transaction
    led_cmd = 2'b01;
    r0 = rises; c0 = cs_low; d0 = done_cnt; h0 = sclk_hi;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_setup_cs_n", cs_n, 1'b0);
    check("t1_setup_busy", busy, 1'b1);
    check("t1_setup_mosi", mosi, 1'b1);
    check("t1_setup_sclk", sclk, 1'b0);
    wait_done("t1", 400);
    check("t1_x",        x_pos, 10'h234);
    check("t1_y",        y_pos, 10'h178);
    check("t1_btn",      btn,   3'b101);
    check("t1_busy_dn",  busy,  1'b0);
    tick();
    check("t1_done_1cy", done,  1'b0);
    check("t1_cs_hi",    cs_n,  1'b1);
    check("t1_mosi_idle", mosi, 1'b0);
    check("t1_rises",    rises - r0,    40);
    check("t1_sclk_hi",  sclk_hi - h0,  80);
    check("t1_mosi",     mosi_cap, {8'h81, 32'h0});
    check("t1_cs_low",   cs_low - c0,   181);
    check("t1_ndone",    done_cnt - d0, 1);
    check("t1_setup_len", first_rise_cyc - fall_cyc, 4);

    // Start while busy is ignored; miso glitches between sample points
    slave_bits = DATA_B;
    glitch_en  = 1'b1;
    r0 = rises; d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_rises("t2", r0 + 10, 200);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t2", 400);
    check("t2_x",   x_pos, 10'h35A);
    check("t2_y",   y_pos, 10'h2C3);
    check("t2_btn", btn,   3'b010);
    glitch_en = 1'b0;
    repeat (300) tick();
    check("t2_ndone",  done_cnt - d0, 1);
    check("t2_busy",   busy, 1'b0);
    check("t2_cs_hi",  cs_n, 1'b1);
    check("idle_pins", idle_err, 0);

    // Reset in the middle of byte 2
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t3_pre_x", x_pos, 10'h000);
    slave_bits = DATA_A;
    r0 = rises;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_rises("t3", r0 + 18, 200);
    d0 = done_cnt;
    reset = 1'b1;
    tick();
    check("t3_cs_n", cs_n, 1'b1);
    check("t3_sclk", sclk, 1'b0);
    check("t3_busy", busy, 1'b0);
    check("t3_mosi", mosi, 1'b0);
    reset = 1'b0;
    repeat (300) tick();
    check("t3_ndone", done_cnt - d0, 0);
    check("t3_x",     x_pos, 10'h000);
    check("t3_y",     y_pos, 10'h000);
    check("t3_btn",   btn,   3'b000);

    // Start held high across two back-to-back transactions
    led_cmd    = 2'b10;
    slave_bits = DATA_A;
    d0 = done_cnt;
    start = 1'b1;
    wait_done("t4a", 400);
    check("t4a_x",   x_pos, 10'h234);
    check("t4a_y",   y_pos, 10'h178);
    check("t4a_btn", btn,   3'b101);
    slave_bits = DATA_B;
    tick();
    check("t4_idle_cs",   cs_n, 1'b1);
    check("t4_idle_busy", busy, 1'b0);
    tick();
    check("t4_restart_cs",   cs_n, 1'b0);
    check("t4_restart_busy", busy, 1'b1);
    wait_done("t4b", 400);
    start = 1'b0;
    check("t4b_x",    x_pos, 10'h35A);
    check("t4b_y",    y_pos, 10'h2C3);
    check("t4b_btn",  btn,   3'b010);
    check("t4b_mosi", mosi_cap, {8'h82, 32'h0});
    check("t4_ndone", done_cnt - d0, 2);
    tick();
    tick();
    check("t4_end_cs",   cs_n, 1'b1);
    check("t4_end_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
